risc_datapath: RTL and testbench
================================

RISC_DATAPATH -- requirements
Module: risc_datapath

Interface
REQ-001: clk  input  1  single clock; all state updates on its rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: sel  input  1  address select from controller (1 = PC, 0 = IR operand).
REQ-004: rd  input  1  memory read strobe request.
REQ-005: ld_ir  input  1  load instruction register from mem_rdata.
REQ-006: halt  input  1  halt request.
REQ-007: inc_pc  input  1  increment program counter.
REQ-008: ld_ac  input  1  load accumulator with ALU result.
REQ-009: wr  input  1  memory write strobe request.
REQ-010: ld_pc  input  1  load PC from IR operand field.
REQ-011: data_e  input  1  drive accumulator onto write-data bus.
REQ-012: mem_rdata  input  8  memory read data.
REQ-013: phase  output  3  current instruction phase, 0..7.
REQ-014: opcode  output  3  ir[7:5].
REQ-015: zero  output  1  1 when ac == 8'h00.
REQ-016: mem_addr  output  5  memory address.
REQ-017: mem_rd, mem_wr  output  1 each  memory read/write strobes.
REQ-018: mem_wdata  output  8  memory write data.
REQ-019: data_oe  output  1  write-data bus enable.
REQ-020: pc  output  5  program counter.
REQ-021: ac  output  8  accumulator.
REQ-022: halted  output  1  sticky halt status.

Function
REQ-023: The phase counter SHALL increment by 1 each clk edge while halted = 0, wrapping from 7 to 0; it SHALL hold its value while halted = 1.
REQ-024: halted SHALL set on the clk edge where halt = 1, stay set until rst, and leave phase at the value it had when halt was sampled +1 mod 8.
REQ-025: While halted = 1, IR, PC and AC SHALL not update, and mem_rd, mem_wr and data_oe SHALL be forced to 0.
REQ-026: IR (8 bits) SHALL load mem_rdata on a clk edge with ld_ir = 1; opcode = ir[7:5] and operand = ir[4:0], both combinational from IR.
REQ-027: mem_addr SHALL be pc when sel = 1, else ir[4:0] (combinational).
REQ-028: PC update SHALL have priority ld_pc > inc_pc: ld_pc loads ir[4:0] as held before the edge; otherwise inc_pc adds 1 modulo 32 (31 -> 0); otherwise PC holds.
REQ-029: On a clk edge with ld_ac = 1, AC SHALL load the ALU result selected by opcode: 2 (ADD) gives ac + mem_rdata modulo 256 with carry discarded; 3 (AND) gives ac & mem_rdata; 4 (XOR) gives ac ^ mem_rdata; 5 (LDA) gives mem_rdata; any other opcode leaves AC unchanged.
REQ-030: zero SHALL be combinational from the current AC, with no register delay.
REQ-031: mem_rd SHALL equal rd, mem_wr SHALL equal wr, and data_oe SHALL equal data_e (subject to REQ-025); mem_wdata SHALL be ac when data_e = 1, else 8'h00.
REQ-032: When ld_ir and ld_pc assert on the same edge, both SHALL take effect; PC receives the old operand.
REQ-033: All load enables SHALL be honoured in any phase; the block SHALL not check phase legality.

Reset
REQ-034: While rst = 1, phase, IR, PC, AC and halted SHALL be 0 asynchronously, giving opcode = 0, zero = 1, mem_addr = 0 (or pc = 0), mem_rdata-independent mem_wdata = 0, and strobes following REQ-031 with halted = 0.
REQ-035: Deassertion of rst SHALL take effect synchronously; the first post-reset clk edge SHALL move phase from 0 to 1.
REQ-036: rst asserted mid-instruction SHALL abort the instruction; no pending load SHALL complete.

Verification
REQ-037: Phase wrap: release reset and clock 9 cycles with no halt -> phase goes 1,2,...,7,0,1.
REQ-038: Fetch and ADD: ac = 8'hF0, ld_ir with mem_rdata = 8'h45 (opcode 2, operand 5), then ld_ac with mem_rdata = 8'h20 -> opcode = 2, ac = 8'h10, zero = 0; sel = 0 -> mem_addr = 5.
REQ-039: PC wrap and priority: pc = 31, inc_pc = 1 -> pc = 0; then ir = 8'hE9 with ld_pc = inc_pc = 1 -> pc = 9.
REQ-040: Store path: ac = 8'h5A, data_e = 1, wr = 1 -> mem_wdata = 8'h5A, data_oe = 1, mem_wr = 1; data_e = 0 -> mem_wdata = 8'h00.
REQ-041: Halt: halt = 1 at phase 4 -> halted = 1 and phase frozen at 5; ld_ac, inc_pc and wr then have no effect, mem_wr = 0.
REQ-042: Async reset: assert rst between edges at phase 6 with ac = 8'h33 -> phase, pc, ac and halted go to 0 immediately and zero = 1.

Source files
------------

// File: rtl/risc_datapath_if.sv
// Controller/memory bus of the accumulator datapath.
// The master modport is the controller/memory side, and the slave modport is the datapath.
interface risc_datapath_if;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e;
  logic [7:0] mem_rdata;
  logic [2:0] phase, opcode;
  logic       zero;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic       data_oe;
  logic [4:0] pc;
  logic [7:0] ac;
  logic       halted;

  modport master (
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e, mem_rdata,
    input  phase, opcode, zero, mem_addr, mem_rd, mem_wr, mem_wdata, data_oe,
           pc, ac, halted
  );

  modport slave (
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e, mem_rdata,
    output phase, opcode, zero, mem_addr, mem_rd, mem_wr, mem_wdata, data_oe,
           pc, ac, halted
  );
endinterface

// File: rtl/risc_datapath.sv
// Accumulator datapath: phase counter, IR, PC, AC and ALU, with a sticky halt.
// The controller decides what happens in each phase; this block only obeys the load enables.
module risc_datapath (
  input logic            clk,
  input logic            rst,
  risc_datapath_if.slave bus
);

  logic [2:0] r_phase;
  logic [7:0] r_ir;
  logic [4:0] r_pc;
  logic [7:0] r_ac;
  logic       r_halted;

  logic [4:0] w_operand;
  logic [2:0] w_opcode;
  logic [7:0] w_alu;

  function automatic logic [7:0] alu(input logic [2:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      3'd2:    alu = a + b;
      3'd3:    alu = a & b;
      3'd4:    alu = a ^ b;
      3'd5:    alu = b;
      default: alu = a;
    endcase
  endfunction

  assign w_operand = r_ir[4:0];
  assign w_opcode  = r_ir[7:5];
  assign w_alu     = alu(w_opcode, r_ac, bus.mem_rdata);

  // The halt edge itself still commits its loads; only later edges are frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= 3'd0;
      r_ir     <= 8'h00;
      r_pc     <= 5'd0;
      r_ac     <= 8'h00;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      r_phase <= r_phase + 3'd1;
      if (bus.halt)
        r_halted <= 1'b1;
      if (bus.ld_ir)
        r_ir <= bus.mem_rdata;
      if (bus.ld_pc)
        r_pc <= w_operand;
      else if (bus.inc_pc)
        r_pc <= r_pc + 5'd1;
      if (bus.ld_ac)
        r_ac <= w_alu;
    end
  end

  assign bus.phase     = r_phase;
  assign bus.opcode    = w_opcode;
  assign bus.zero      = (r_ac == 8'h00);
  assign bus.mem_addr  = bus.sel ? r_pc : w_operand;
  assign bus.mem_rd    = bus.rd     & ~r_halted;
  assign bus.mem_wr    = bus.wr     & ~r_halted;
  assign bus.data_oe   = bus.data_e & ~r_halted;
  assign bus.mem_wdata = bus.data_e ? r_ac : 8'h00;
  assign bus.pc        = r_pc;
  assign bus.ac        = r_ac;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_risc_datapath.sv
// Bench for risc_datapath: directed vector table, hand-written corner sequences,
// and random cycles compared against a behavioural model.
module tb_risc_datapath;

  logic clk = 1'b0;
  logic rst = 1'b1;
  risc_datapath_if bus();

  risc_datapath dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e;
    logic [7:0] rdata;
  } ctl_t;

  typedef struct {
    ctl_t c;
    int   ph, opc, pc, ac, addr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_phase, m_ir, m_pc, m_ac;
  bit m_halted;

  function automatic ctl_t mk(input bit ldir, input bit ldac, input bit incpc,
                              input bit ldpc, input bit s, input int rdata);
    ctl_t c;
    c        = '0;
    c.ld_ir  = ldir;
    c.ld_ac  = ldac;
    c.inc_pc = incpc;
    c.ld_pc  = ldpc;
    c.sel    = s;
    c.rdata  = rdata[7:0];
    return c;
  endfunction

  task automatic drive(input ctl_t c);
    bus.sel = c.sel; bus.rd = c.rd; bus.ld_ir = c.ld_ir; bus.halt = c.halt;
    bus.inc_pc = c.inc_pc; bus.ld_ac = c.ld_ac; bus.wr = c.wr;
    bus.ld_pc = c.ld_pc; bus.data_e = c.data_e; bus.mem_rdata = c.rdata;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ir = 0; m_pc = 0; m_ac = 0; m_halted = 0;
  endtask

  task automatic model_edge();
    int n_ir, n_pc, n_ac, rdv;
    rdv  = int'(bus.mem_rdata);
    n_ir = m_ir; n_pc = m_pc; n_ac = m_ac;
    if (!m_halted) begin
      if (bus.ld_ir) n_ir = rdv;
      if (bus.ld_pc) n_pc = m_ir % 32;
      else if (bus.inc_pc) n_pc = (m_pc + 1) % 32;
      if (bus.ld_ac)
        case (m_ir / 32)
          2: n_ac = (m_ac + rdv) % 256;
          3: n_ac = m_ac & rdv;
          4: n_ac = m_ac ^ rdv;
          5: n_ac = rdv;
          default: n_ac = m_ac;
        endcase
      m_phase = (m_phase + 1) % 8;
      if (bus.halt) m_halted = 1;
      m_ir = n_ir; m_pc = n_pc; m_ac = n_ac;
    end
  endtask

  task automatic check_all();
    chk("phase",  int'(bus.phase),  m_phase);
    chk("opcode", int'(bus.opcode), m_ir / 32);
    chk("pc",     int'(bus.pc),     m_pc);
    chk("ac",     int'(bus.ac),     m_ac);
    chk("zero",   int'(bus.zero),   (m_ac == 0) ? 1 : 0);
    chk("halted", int'(bus.halted), int'(m_halted));
    chk("mem_addr", int'(bus.mem_addr), bus.sel ? m_pc : (m_ir % 32));
    chk("mem_rd",  int'(bus.mem_rd),  (bus.rd && !m_halted) ? 1 : 0);
    chk("mem_wr",  int'(bus.mem_wr),  (bus.wr && !m_halted) ? 1 : 0);
    chk("data_oe", int'(bus.data_oe), (bus.data_e && !m_halted) ? 1 : 0);
    chk("mem_wdata", int'(bus.mem_wdata), bus.data_e ? m_ac : 0);
  endtask

  // Inputs must already be driven; model is updated from the pre-edge inputs.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    ctl_t c;
    int   guard;

    tbl[0]  = '{mk(1,0,0,0,1,8'hA0), 1, 5, 0, 8'h00, 0};
    tbl[1]  = '{mk(0,1,0,0,1,8'hF0), 2, 5, 0, 8'hF0, 0};
    tbl[2]  = '{mk(1,0,0,0,0,8'h45), 3, 2, 0, 8'hF0, 5};
    tbl[3]  = '{mk(0,1,0,0,0,8'h20), 4, 2, 0, 8'h10, 5};
    tbl[4]  = '{mk(0,0,1,0,1,8'h00), 5, 2, 1, 8'h10, 1};
    tbl[5]  = '{mk(1,0,1,1,0,8'hE9), 6, 7, 5, 8'h10, 9};
    tbl[6]  = '{mk(0,0,1,1,1,8'h00), 7, 7, 9, 8'h10, 9};
    tbl[7]  = '{mk(0,1,0,0,0,8'hFF), 0, 7, 9, 8'h10, 9};
    tbl[8]  = '{mk(1,0,0,0,0,8'h7C), 1, 3, 9, 8'h10, 28};
    tbl[9]  = '{mk(0,1,0,0,0,8'h3C), 2, 3, 9, 8'h10, 28};
    tbl[10] = '{mk(1,0,0,0,1,8'h8F), 3, 4, 9, 8'h10, 9};
    tbl[11] = '{mk(0,1,0,0,1,8'h10), 4, 4, 9, 8'h00, 9};

    // Reset state
    drive('0);
    #3;
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_pc",    int'(bus.pc),    0);
    chk("rst_ac",    int'(bus.ac),    0);
    chk("rst_zero",  int'(bus.zero),  1);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_wdata", int'(bus.mem_wdata), 0);
    do_reset();

    // Directed vectors: fetch, ADD with carry discard, PC priority, AND, XOR, phase wrap
    foreach (tbl[i]) begin
      drive(tbl[i].c);
      tick();
      chk($sformatf("v%0d_phase", i),  int'(bus.phase),    tbl[i].ph);
      chk($sformatf("v%0d_opcode", i), int'(bus.opcode),   tbl[i].opc);
      chk($sformatf("v%0d_pc", i),     int'(bus.pc),       tbl[i].pc);
      chk($sformatf("v%0d_ac", i),     int'(bus.ac),       tbl[i].ac);
      chk($sformatf("v%0d_addr", i),   int'(bus.mem_addr), tbl[i].addr);
    end

    // PC wrap 31 -> 0, then ld_pc beats inc_pc
    drive(mk(1,0,0,0,1,8'h1F)); tick();
    drive(mk(0,0,0,1,1,8'h00)); tick();
    chk("pc_load31", int'(bus.pc), 31);
    drive(mk(0,0,1,0,1,8'h00)); tick();
    chk("pc_wrap", int'(bus.pc), 0);
    drive(mk(1,0,0,0,1,8'hE9)); tick();
    drive(mk(0,0,1,1,1,8'h00)); tick();
    chk("pc_prio", int'(bus.pc), 9);

    // Store path
    drive(mk(1,0,0,0,1,8'hA0)); tick();
    drive(mk(0,1,0,0,1,8'h5A)); tick();
    drive('0);
    bus.data_e = 1'b1; bus.wr = 1'b1;
    #1;
    chk("st_wdata", int'(bus.mem_wdata), 8'h5A);
    chk("st_oe",    int'(bus.data_oe),   1);
    chk("st_wr",    int'(bus.mem_wr),    1);
    bus.data_e = 1'b0;
    #1;
    chk("st_wdata_off", int'(bus.mem_wdata), 0);
    chk("st_oe_off",    int'(bus.data_oe),   0);

    // Random cycles against the model
    for (int n = 0; n < 400; n++) begin
      c        = '0;
      c.sel    = 1'($urandom_range(0, 1));
      c.rd     = 1'($urandom_range(0, 1));
      c.ld_ir  = 1'($urandom_range(0, 1));
      c.inc_pc = 1'($urandom_range(0, 1));
      c.ld_ac  = 1'($urandom_range(0, 1));
      c.wr     = 1'($urandom_range(0, 1));
      c.ld_pc  = 1'($urandom_range(0, 1));
      c.data_e = 1'($urandom_range(0, 1));
      c.rdata  = 8'($urandom_range(0, 255));
      drive(c);
      tick();
    end

    // Halt at phase 4 freezes phase at 5 and blocks all loads and strobes
    do_reset();
    drive(mk(1,0,0,0,1,8'hA0)); tick();
    drive('0);
    guard = 0;
    while (m_phase != 4 && guard < 8) begin tick(); guard++; end
    chk("halt_pre_phase", int'(bus.phase), 4);
    c = '0; c.halt = 1'b1; drive(c); tick();
    chk("halt_set",   int'(bus.halted), 1);
    chk("halt_phase", int'(bus.phase),  5);
    for (int n = 0; n < 3; n++) begin
      c = mk(1,1,1,0,1,8'h77);
      c.wr = 1'b1; c.rd = 1'b1; c.data_e = 1'b1;
      drive(c);
      tick();
    end
    chk("halt_ac",     int'(bus.ac),     0);
    chk("halt_pc",     int'(bus.pc),     0);
    chk("halt_opcode", int'(bus.opcode), 5);
    chk("halt_frozen", int'(bus.phase),  5);
    chk("halt_wr",     int'(bus.mem_wr), 0);

    // Asynchronous reset mid-instruction at phase 6
    do_reset();
    drive(mk(1,0,0,0,1,8'hA0)); tick();
    drive(mk(0,1,0,0,1,8'h33)); tick();
    drive(mk(0,0,1,0,1,8'h00)); tick();
    drive('0); bus.sel = 1'b1;
    guard = 0;
    while (m_phase != 6 && guard < 8) begin tick(); guard++; end
    chk("ar_pre_phase", int'(bus.phase), 6);
    chk("ar_pre_ac",    int'(bus.ac),    8'h33);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_phase",  int'(bus.phase),    0);
    chk("ar_pc",     int'(bus.pc),       0);
    chk("ar_ac",     int'(bus.ac),       0);
    chk("ar_halted", int'(bus.halted),   0);
    chk("ar_zero",   int'(bus.zero),     1);
    chk("ar_addr",   int'(bus.mem_addr), 0);
    model_reset();
    drive(mk(1,1,1,0,1,8'h55));
    @(posedge clk);
    #1;
    chk("ar_hold_ac",    int'(bus.ac),    0);
    chk("ar_hold_phase", int'(bus.phase), 0);
    rst = 1'b0;
    drive('0);
    tick();
    chk("ar_first_phase", int'(bus.phase), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
